// File: rtl/pixel_writer.sv
// Pixel pair packer: collects two 24-bit RGB pixels into one 48-bit memory
// word and writes it at a frame-relative word address. The address wraps
// after MAX_ADDR, and FRAME_DONE pulses to mark the end of a frame.
// Every output comes straight from a register, so the memory side sees
// glitch-free strobes.
module pixel_writer #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_ADDR = 31
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [23:0]       RGB_IN,
  input  logic              PIXEL_VALID,
  input  logic              FRAME_START,
  input  logic              INTERFACE_EN,
  output logic              PIXEL_READY,
  output logic [47:0]       DATA_OUT,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic              FRAME_DONE
);

  localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(MAX_ADDR);

  typedef enum logic [2:0] {
    StFirst,
    StSecond,
    StWait,
    StWrite,
    StIncr
  } state_e;

  state_e            r_state;
  logic              r_ready;
  logic              r_we;
  logic              r_done;
  logic [47:0]       r_data;
  logic [ADDR_W-1:0] r_addr;

  logic              w_at_max;

  // Last word of the frame is being retired in INCR.
  assign w_at_max = (r_addr == MaxAddr);

  // Single-process FSM. The ready, strobe and done outputs are registered
  // alongside the state, so each one is set on the edge that enters the
  // state it belongs to.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StFirst;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
    end else if (FRAME_START) begin
      // Restart wins over everything else. Any half-built word is dropped.
      // A strobe already on the bus this cycle still completes.
      r_state <= StFirst;
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StFirst: begin
          if (PIXEL_VALID) begin
            r_data[47:24] <= RGB_IN;
            r_state       <= StSecond;
          end
        end
        StSecond: begin
          if (PIXEL_VALID) begin
            r_data[23:0] <= RGB_IN;
            r_state      <= StWait;
            r_ready      <= 1'b0;
          end
        end
        StWait: begin
          // Stall here for as long as the memory side needs.
          if (INTERFACE_EN) begin
            r_state <= StWrite;
            r_we    <= 1'b1;
          end
        end
        StWrite: begin
          r_state <= StIncr;
        end
        StIncr: begin
          if (w_at_max) begin
            r_addr <= '0;
            r_done <= 1'b1;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
          r_state <= StFirst;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= StFirst;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign PIXEL_READY = r_ready;
  assign DATA_OUT    = r_data;
  assign MEM_ADDR    = r_addr;
  assign MEM_WE      = r_we;
  assign FRAME_DONE  = r_done;

endmodule
